// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants and types for the trap sequencer.
//   - CSR addresses written or read through the CLINT-side port
//   - mcause codes for ecall, ebreak and the machine timer interrupt
//   - mstatus bit positions touched on trap entry and mret
//   - FSM state encoding
package trap_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // CSR addresses (upper bits zero on the write port)
  localparam logic [XLEN-1:0] CsrAddrMstatus = 32'h0000_0300;
  localparam logic [XLEN-1:0] CsrAddrMtvec   = 32'h0000_0305;
  localparam logic [XLEN-1:0] CsrAddrMepc    = 32'h0000_0341;
  localparam logic [XLEN-1:0] CsrAddrMcause  = 32'h0000_0342;

  // mcause values
  localparam logic [XLEN-1:0] CauseEcall    = 32'd11;
  localparam logic [XLEN-1:0] CauseEbreak   = 32'd3;
  localparam logic [XLEN-1:0] CauseTimerInt = 32'h8000_0007;

  // mstatus bit indices
  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  typedef enum logic [2:0] {
    StIdle,
    StWMepc,
    StWMstatus,
    StWMcause,
    StEnter,
    StRMstatus,
    StRJump
  } trap_state_e;

  // States that drive the CSR write port and stall on a WB collision.
  function automatic logic is_write_state(trap_state_e st);
    return (st == StWMepc) || (st == StWMstatus) || (st == StWMcause) || (st == StRMstatus);
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundles every non-clock signal of the trap sequencer.
//   Suffixes are from the sequencer's point of view (_i into it, _o out of it).
//   slave  modport : the trap sequencer itself
//   master modport : surrounding pipeline / CSR file / fetch logic
// Optional: TRAP_CTRL_TIMER_INT_EN adds the level timer interrupt request int_flag_i.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  // Decode / execute stage
  logic            inst_ecall_i;
  logic            inst_ebreak_i;
  logic            inst_mret_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            jump_flag_i;
  logic [XLEN-1:0] jump_addr_i;
`ifdef TRAP_CTRL_TIMER_INT_EN
  logic            int_flag_i;
`endif
  // CSR file
  logic            global_int_en_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic [XLEN-1:0] csr_mstatus_i;
  logic            wb_csr_we_i;
  // Outputs
  logic            hold_flag_o;
  logic            we_o;
  logic [XLEN-1:0] waddr_o;
  logic [XLEN-1:0] wdata_o;
  logic            int_assert_o;
  logic [XLEN-1:0] int_addr_o;

  modport slave (
    input  inst_ecall_i,
    input  inst_ebreak_i,
    input  inst_mret_i,
    input  inst_addr_i,
    input  jump_flag_i,
    input  jump_addr_i,
`ifdef TRAP_CTRL_TIMER_INT_EN
    input  int_flag_i,
`endif
    input  global_int_en_i,
    input  csr_mtvec_i,
    input  csr_mepc_i,
    input  csr_mstatus_i,
    input  wb_csr_we_i,
    output hold_flag_o,
    output we_o,
    output waddr_o,
    output wdata_o,
    output int_assert_o,
    output int_addr_o
  );

  modport master (
    output inst_ecall_i,
    output inst_ebreak_i,
    output inst_mret_i,
    output inst_addr_i,
    output jump_flag_i,
    output jump_addr_i,
`ifdef TRAP_CTRL_TIMER_INT_EN
    output int_flag_i,
`endif
    output global_int_en_i,
    output csr_mtvec_i,
    output csr_mepc_i,
    output csr_mstatus_i,
    output wb_csr_we_i,
    input  hold_flag_o,
    input  we_o,
    input  waddr_o,
    input  wdata_o,
    input  int_assert_o,
    input  int_addr_o
  );

endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer owning the CLINT-side CSR write port.
//   Detects ecall/ebreak, mret and (optionally) the machine timer interrupt,
//   stalls the pipeline, writes mepc -> mstatus -> mcause one per cycle and
//   then redirects fetch to mtvec; mret rewrites mstatus and redirects to mepc.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : trap_ctrl_if.slave (decode requests, live CSR values, WB collision
//            flag, stall, CSR write port, fetch redirect)
// Optional feature: define TRAP_CTRL_TIMER_INT_EN to accept the level timer
// interrupt (bus.int_flag_i) when global_int_en_i is set.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  trap_ctrl_if.slave     bus
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] ret_pc_q, ret_pc_d;

  logic req_exc;
  logic req_mret;
  logic req_int;

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [XLEN-1:0] mstatus_on_trap(logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r                 = m;
    r[MstatusMpieBit] = m[MstatusMieBit];
    r[MstatusMieBit]  = 1'b0;
    return r;
  endfunction

  // mstatus on mret: MIE <- MPIE, MPIE <- 1.
  function automatic logic [XLEN-1:0] mstatus_on_mret(logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r                 = m;
    r[MstatusMieBit]  = m[MstatusMpieBit];
    r[MstatusMpieBit] = 1'b1;
    return r;
  endfunction

  always_comb begin
    req_exc  = bus.inst_ecall_i | bus.inst_ebreak_i;
    req_mret = bus.inst_mret_i;
`ifdef TRAP_CTRL_TIMER_INT_EN
    req_int  = bus.int_flag_i & bus.global_int_en_i;
`else
    req_int  = 1'b0;
`endif
  end

`ifndef TRAP_CTRL_TIMER_INT_EN
  // Without the timer interrupt these inputs have no consumer.
  logic unused_int_inputs;
  assign unused_int_inputs = ^{bus.global_int_en_i, bus.jump_flag_i, bus.jump_addr_i};
`endif

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    ret_pc_d         = ret_pc_q;
    bus.hold_flag_o  = 1'b0;
    bus.we_o         = 1'b0;
    bus.waddr_o      = '0;
    bus.wdata_o      = '0;
    bus.int_assert_o = 1'b0;
    bus.int_addr_o   = '0;

    unique case (state_q)
      StIdle: begin
        // Priority: synchronous exception > mret > interrupt.
        if (req_exc) begin
          state_d         = StWMepc;
          cause_d         = bus.inst_ecall_i ? CauseEcall : CauseEbreak;
          ret_pc_d        = bus.inst_addr_i;
          bus.hold_flag_o = 1'b1;
        end else if (req_mret) begin
          state_d         = StRMstatus;
          bus.hold_flag_o = 1'b1;
        end else if (req_int) begin
          // A redirecting instruction has already committed; resume at its target.
          state_d         = StWMepc;
          cause_d         = CauseTimerInt;
          ret_pc_d        = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
          bus.hold_flag_o = 1'b1;
        end
      end

      StWMepc: begin
        bus.hold_flag_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.waddr_o     = CsrAddrMepc;
        bus.wdata_o     = ret_pc_q;
        if (!bus.wb_csr_we_i) state_d = StWMstatus;
      end

      StWMstatus: begin
        bus.hold_flag_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.waddr_o     = CsrAddrMstatus;
        bus.wdata_o     = mstatus_on_trap(bus.csr_mstatus_i);
        if (!bus.wb_csr_we_i) state_d = StWMcause;
      end

      StWMcause: begin
        bus.hold_flag_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.waddr_o     = CsrAddrMcause;
        bus.wdata_o     = cause_q;
        if (!bus.wb_csr_we_i) state_d = StEnter;
      end

      StEnter: begin
        bus.hold_flag_o  = 1'b1;
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = bus.csr_mtvec_i;
        state_d          = StIdle;
      end

      StRMstatus: begin
        bus.hold_flag_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.waddr_o     = CsrAddrMstatus;
        bus.wdata_o     = mstatus_on_mret(bus.csr_mstatus_i);
        if (!bus.wb_csr_we_i) state_d = StRJump;
      end

      StRJump: begin
        bus.hold_flag_o  = 1'b1;
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = bus.csr_mepc_i;
        state_d          = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cause_q  <= '0;
      ret_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      ret_pc_q <= ret_pc_d;
    end
  end

`ifndef SYNTHESIS
  // A write state must always present a write.
  always_comb begin
    if (rst_n && is_write_state(state_q)) begin
      assert (bus.we_o) else $error("write state without we_o");
    end
  end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Expected per-cycle outputs are pushed to a
// scoreboard queue when a request is driven and popped one per cycle.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trap_ctrl_if bus();

  trap_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  function automatic exp_t e_idle();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t e_hold();
    exp_t e = '0;
    e.hold = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_wr(logic [31:0] a, logic [31:0] d);
    exp_t e = '0;
    e.hold  = 1'b1;
    e.we    = 1'b1;
    e.waddr = a;
    e.wdata = d;
    return e;
  endfunction

  function automatic exp_t e_jmp(logic [31:0] a);
    exp_t e = '0;
    e.hold  = 1'b1;
    e.ia    = 1'b1;
    e.iaddr = a;
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples 1 time unit after the caller's drive point (away from posedge).
  task automatic check(string tag);
    exp_t e;
    #1;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp({tag, ".hold"},  {31'd0, bus.hold_flag_o},  {31'd0, e.hold});
      cmp({tag, ".we"},    {31'd0, bus.we_o},         {31'd0, e.we});
      cmp({tag, ".waddr"}, bus.waddr_o,               e.waddr);
      cmp({tag, ".wdata"}, bus.wdata_o,               e.wdata);
      cmp({tag, ".ia"},    {31'd0, bus.int_assert_o}, {31'd0, e.ia});
      cmp({tag, ".iaddr"}, bus.int_addr_o,            e.iaddr);
    end
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag);
    end
  endtask

  task automatic clear_req();
    bus.inst_ecall_i  = 1'b0;
    bus.inst_ebreak_i = 1'b0;
    bus.inst_mret_i   = 1'b0;
    bus.jump_flag_i   = 1'b0;
    bus.wb_csr_we_i   = 1'b0;
`ifdef TRAP_CTRL_TIMER_INT_EN
    bus.int_flag_i    = 1'b0;
`endif
  endtask

  // Push the full trap-entry sequence with no collisions.
  task automatic push_trap(logic [31:0] mepc, logic [31:0] mst, logic [31:0] cause,
                           logic [31:0] mtvec);
    sb.push_back(e_hold());
    sb.push_back(e_wr(32'h341, mepc));
    sb.push_back(e_wr(32'h300, mst));
    sb.push_back(e_wr(32'h342, cause));
    sb.push_back(e_jmp(mtvec));
    sb.push_back(e_idle());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b1;
    clear_req();
    bus.inst_addr_i     = '0;
    bus.jump_addr_i     = '0;
    bus.global_int_en_i = 1'b0;
    bus.csr_mtvec_i     = '0;
    bus.csr_mepc_i      = '0;
    bus.csr_mstatus_i   = '0;
    #1 rst_n = 1'b0;

    // Reset state
    sb.push_back(e_idle());
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(e_idle());
    check("idle");

    // ecall: mstatus 0x8 -> 0x80, cause 11, redirect to mtvec at T+4
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_0008;
    bus.csr_mtvec_i   = 32'h8000_0100;
    bus.inst_addr_i   = 32'h8000_0010;
    bus.inst_ecall_i  = 1'b1;
    push_trap(32'h8000_0010, 32'h0000_0080, 32'd11, 32'h8000_0100);
    check("ecall_t0");
    @(negedge clk);
    clear_req();
    bus.inst_addr_i = 32'hdead_beef;
    check("ecall_t1");
    run("ecall", 4);

    // mret: mstatus 0x80 -> 0x88, redirect to mepc at T+2
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_0080;
    bus.csr_mepc_i    = 32'h8000_0014;
    bus.inst_mret_i   = 1'b1;
    sb.push_back(e_hold());
    sb.push_back(e_wr(32'h300, 32'h0000_0088));
    sb.push_back(e_jmp(32'h8000_0014));
    sb.push_back(e_idle());
    check("mret_t0");
    @(negedge clk);
    clear_req();
    check("mret_t1");
    run("mret", 2);

    // ebreak: cause 3, MIE=0 keeps MPIE=0, other bits preserved
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_1800;
    bus.inst_addr_i   = 32'h8000_0030;
    bus.inst_ebreak_i = 1'b1;
    push_trap(32'h8000_0030, 32'h0000_1800, 32'd3, 32'h8000_0100);
    check("ebreak_t0");
    @(negedge clk);
    clear_req();
    check("ebreak_t1");
    run("ebreak", 4);

    // ecall + mret (+ interrupt) together: only the ecall trap
    @(negedge clk);
    bus.csr_mstatus_i   = 32'h0000_0008;
    bus.inst_addr_i     = 32'h8000_0040;
    bus.jump_flag_i     = 1'b1;
    bus.jump_addr_i     = 32'h8000_0444;
    bus.inst_ecall_i    = 1'b1;
    bus.inst_mret_i     = 1'b1;
    bus.global_int_en_i = 1'b1;
`ifdef TRAP_CTRL_TIMER_INT_EN
    bus.int_flag_i      = 1'b1;
`endif
    push_trap(32'h8000_0040, 32'h0000_0080, 32'd11, 32'h8000_0100);
    check("prio_t0");
    @(negedge clk);
    clear_req();
    bus.global_int_en_i = 1'b0;
    check("prio_t1");
    run("prio", 4);

`ifdef TRAP_CTRL_TIMER_INT_EN
    // Timer interrupt while EX redirects: mepc takes the jump target
    @(negedge clk);
    bus.csr_mstatus_i   = 32'h0000_0008;
    bus.global_int_en_i = 1'b1;
    bus.int_flag_i      = 1'b1;
    bus.inst_addr_i     = 32'h8000_0048;
    bus.jump_flag_i     = 1'b1;
    bus.jump_addr_i     = 32'h8000_0200;
    push_trap(32'h8000_0200, 32'h0000_0080, 32'h8000_0007, 32'h8000_0100);
    check("tint_t0");
    @(negedge clk);
    clear_req();
    bus.global_int_en_i = 1'b0;
    check("tint_t1");
    run("tint", 4);

    // Interrupt masked: nothing happens until MIE rises
    @(negedge clk);
    bus.int_flag_i  = 1'b1;
    bus.inst_addr_i = 32'h8000_0050;
    sb.push_back(e_idle());
    check("masked_a");
    @(negedge clk);
    sb.push_back(e_idle());
    check("masked_b");
    @(negedge clk);
    bus.global_int_en_i = 1'b1;
    push_trap(32'h8000_0050, 32'h0000_0080, 32'h8000_0007, 32'h8000_0100);
    check("unmask_t0");
    @(negedge clk);
    clear_req();
    bus.global_int_en_i = 1'b0;
    check("unmask_t1");
    run("unmask", 4);
`endif

    // WB collision for 2 cycles in W_MSTATUS: write held 3 cycles, assert at T+6
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_1808;
    bus.inst_addr_i   = 32'h8000_0020;
    bus.inst_ecall_i  = 1'b1;
    sb.push_back(e_hold());
    sb.push_back(e_wr(32'h341, 32'h8000_0020));
    sb.push_back(e_wr(32'h300, 32'h0000_1880));
    sb.push_back(e_wr(32'h300, 32'h0000_1880));
    sb.push_back(e_wr(32'h300, 32'h0000_1880));
    sb.push_back(e_wr(32'h342, 32'd11));
    sb.push_back(e_jmp(32'h8000_0100));
    sb.push_back(e_idle());
    check("wb_t0");
    @(negedge clk);
    clear_req();
    check("wb_t1");
    @(negedge clk);
    bus.wb_csr_we_i = 1'b1;
    check("wb_t2");
    @(negedge clk);
    check("wb_t3");
    @(negedge clk);
    bus.wb_csr_we_i = 1'b0;
    check("wb_t4");
    run("wb", 3);

    // Reset at T+2 aborts immediately
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_0008;
    bus.inst_addr_i   = 32'h8000_0060;
    bus.inst_ecall_i  = 1'b1;
    sb.push_back(e_hold());
    sb.push_back(e_wr(32'h341, 32'h8000_0060));
    sb.push_back(e_wr(32'h300, 32'h0000_0080));
    check("rst_t0");
    @(negedge clk);
    clear_req();
    check("rst_t1");
    @(negedge clk);
    check("rst_t2");
    #1 rst_n = 1'b0;
    sb.push_back(e_idle());
    check("rst_async");
    @(negedge clk);
    sb.push_back(e_idle());
    check("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(e_idle());
    check("rst_release");

    // Recovery after reset: a plain mret
    @(negedge clk);
    bus.csr_mstatus_i = 32'h0000_0000;
    bus.csr_mepc_i    = 32'h8000_0070;
    bus.inst_mret_i   = 1'b1;
    sb.push_back(e_hold());
    sb.push_back(e_wr(32'h300, 32'h0000_0080));
    sb.push_back(e_jmp(32'h8000_0070));
    sb.push_back(e_idle());
    check("rec_t0");
    @(negedge clk);
    clear_req();
    check("rec_t1");
    run("rec", 2);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
